// File: rtl/stage_mem_pkg.sv
// Shared pipeline definitions: instruction classes, load/store widths and
// the memory-stage FSM encoding.
package stage_mem_pkg;

   // Major opcodes handled by the memory stage
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // funct3 width codes shared by loads and stores (BU/HU are load-only)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } mem_state_e;

   // Byte address of byte 'off' of an access; wraps modulo 2^32
   function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                             input logic [1:0]  off);
      return base + {30'd0, off};
   endfunction

endpackage

// File: rtl/stage_mem_load_ext.sv
// Width decode for load/store funct3 and sign/zero extension of the
// assembled load value. Purely combinational.
import stage_mem_pkg::*;

module load_ext (
   input  logic [2:0]  funct3_i,
   input  logic        is_store_i,
   input  logic [31:0] raw_i,
   output logic [2:0]  nbytes_o,
   output logic        width_ok_o,
   output logic [31:0] ext_o
);

   // Byte count, legality and extended value per funct3
   always_comb begin
      nbytes_o   = 3'd1;
      width_ok_o = 1'b0;
      ext_o      = raw_i;
      case (funct3_i)
         F3_B: begin
            nbytes_o   = 3'd1;
            width_ok_o = 1'b1;
            ext_o      = {{24{raw_i[7]}}, raw_i[7:0]};
         end
         F3_H: begin
            nbytes_o   = 3'd2;
            width_ok_o = 1'b1;
            ext_o      = {{16{raw_i[15]}}, raw_i[15:0]};
         end
         F3_W: begin
            nbytes_o   = 3'd4;
            width_ok_o = 1'b1;
            ext_o      = raw_i;
         end
         F3_BU: begin
            nbytes_o   = 3'd1;
            width_ok_o = ~is_store_i;
            ext_o      = {24'd0, raw_i[7:0]};
         end
         F3_HU: begin
            nbytes_o   = 3'd2;
            width_ok_o = ~is_store_i;
            ext_o      = {16'd0, raw_i[15:0]};
         end
         default: begin
            nbytes_o   = 3'd1;
            width_ok_o = 1'b0;
            ext_o      = raw_i;
         end
      endcase
   end

endmodule

// File: rtl/stage_mem.sv
// Memory stage: sequences multi-byte loads and stores over a byte-wide RAM,
// stalling the front of the pipeline until the access completes.
import stage_mem_pkg::*;

module stage_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] mem_addr_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] mem_a_o,
   output logic        mem_we_o,
   output logic [7:0]  mem_dout_o,
   input  logic [7:0]  mem_din_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stall_req_o
);

   mem_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] asm_q, asm_d;

   logic        is_load, is_store;
   logic [2:0]  nbytes;
   logic        width_ok;
   logic [31:0] ext_data;
   logic [1:0]  last_idx;
   logic        is_last;
   logic [1:0]  cnt_nx;

   assign is_load  = (opcode_i == OP_LOAD);
   assign is_store = (opcode_i == OP_STORE);

   load_ext u_load_ext (
      .funct3_i   (funct3_i),
      .is_store_i (is_store),
      .raw_i      (asm_q),
      .nbytes_o   (nbytes),
      .width_ok_o (width_ok),
      .ext_o      (ext_data)
   );

   // n is 1, 2 or 4, so the last byte index always fits the 2-bit counter
   assign last_idx = nbytes[1:0] - 2'd1;
   assign is_last  = (cnt_q == last_idx);
   assign cnt_nx   = cnt_q + 2'd1;

   // Next-state, byte sequencing and writeback muxing
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      mem_a_o     = 32'd0;
      mem_we_o    = 1'b0;
      mem_dout_o  = 8'd0;
      wd_o        = wd_i;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      stall_req_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_load && width_ok) begin
               stall_req_o = 1'b1;
               mem_a_o     = byte_addr(mem_addr_i, 2'd0);
               asm_d       = 32'd0;
               cnt_d       = 2'd0;
               state_d     = ST_LOAD;
            end else if (is_store && width_ok) begin
               stall_req_o = 1'b1;
               mem_a_o     = byte_addr(mem_addr_i, 2'd0);
               mem_dout_o  = wdata_i[7:0];
               mem_we_o    = 1'b1;
               cnt_d       = 2'd1;
               state_d     = (nbytes == 3'd1) ? ST_DONE : ST_STORE;
            end else if (!is_load && !is_store) begin
               wreg_o  = wreg_i;
               wdata_o = wdata_i;
            end
            // an illegal width under LOAD/STORE falls through as a no-op
         end
         ST_LOAD: begin
            stall_req_o = 1'b1;
            asm_d[{cnt_q, 3'b000} +: 8] = mem_din_i;
            // While frozen, re-present the byte still owed so the RAM's
            // one-cycle read latency lines up when capture resumes.
            mem_a_o = rdy ? byte_addr(mem_addr_i, cnt_nx)
                          : byte_addr(mem_addr_i, cnt_q);
            if (is_last) state_d = ST_DONE;
            else         cnt_d   = cnt_nx;
         end
         ST_STORE: begin
            stall_req_o = 1'b1;
            mem_a_o     = byte_addr(mem_addr_i, cnt_q);
            mem_dout_o  = wdata_i[{cnt_q, 3'b000} +: 8];
            mem_we_o    = 1'b1;
            if (is_last) state_d = ST_DONE;
            else         cnt_d   = cnt_nx;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            if (is_load) begin
               wreg_o  = wreg_i;
               wdata_o = ext_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rdy) begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         asm_d    = asm_q;
         mem_we_o = 1'b0;
      end

      if (rst) begin
         mem_a_o     = 32'd0;
         mem_we_o    = 1'b0;
         mem_dout_o  = 8'd0;
         wd_o        = 5'd0;
         wreg_o      = 1'b0;
         wdata_o     = 32'd0;
         stall_req_o = 1'b0;
      end
   end

   // State, byte counter and assembly register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         asm_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with a byte-wide synchronous RAM model.
module tb_stage_mem;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_ADD   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] mem_addr;
   logic [4:0]  wd;
   logic        wreg;
   logic [31:0] wdata;
   logic [31:0] mem_a_o;
   logic        mem_we_o;
   logic [7:0]  mem_dout_o;
   logic [7:0]  mem_din;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req_o;

   logic [7:0]  ram [0:1023];
   logic        pl_en;
   logic [9:0]  pl_a;
   logic [7:0]  pl_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_mem dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .opcode_i(opcode), .funct3_i(funct3), .mem_addr_i(mem_addr),
      .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
      .mem_a_o(mem_a_o), .mem_we_o(mem_we_o), .mem_dout_o(mem_dout_o),
      .mem_din_i(mem_din),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stall_req_o(stall_req_o)
   );

   // RAM: read data valid the cycle after the address; preload port for setup
   always @(posedge clk) begin
      if (pl_en)         ram[pl_a] <= pl_d;
      else if (mem_we_o) ram[mem_a_o[9:0]] <= mem_dout_o;
      mem_din <= ram[mem_a_o[9:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic nop();
      opcode = OPC_ADD; funct3 = 3'd0; wd = 5'd0; wreg = 1'b0; wdata = 32'd0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the DONE cycle
   task automatic run_load(input string tag, input logic [31:0] base, input logic [2:0] f3,
                           input int n, input logic [31:0] exp, input int exp_stall,
                           input int rdy_at);
      int cyc = 0;
      int adv = 0;
      opcode = OPC_LOAD; funct3 = f3; mem_addr = base; wd = 5'd7; wreg = 1'b1; wdata = 32'h0;
      rdy = 1'b1;
      while (1) begin
         if (cyc == rdy_at)     rdy = 1'b0;
         if (cyc == rdy_at + 2) rdy = 1'b1;
         #1;
         if (!stall_req_o) break;
         if (cyc > 30) begin chk({tag, "_timeout"}, {31'd0, stall_req_o}, 32'd0); break; end
         chk({tag, "_wreg_stall"}, {31'd0, wreg_o}, 32'd0);
         chk({tag, "_wdata_stall"}, wdata_o, 32'd0);
         chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
         if (rdy) begin
            if (adv < n) chk({tag, "_addr"}, mem_a_o, base + adv);
            adv++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      chk({tag, "_stall_len"}, cyc, exp_stall);
      chk({tag, "_wdata"}, wdata_o, exp);
      chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd1);
      chk({tag, "_wd"}, {27'd0, wd_o}, 32'd7);
      @(posedge clk); #1;
      nop();
   endtask

   task automatic run_store(input string tag, input logic [31:0] base, input logic [2:0] f3,
                            input int n, input logic [31:0] d);
      int cyc = 0;
      int nw = 0;
      opcode = OPC_STORE; funct3 = f3; mem_addr = base; wd = 5'd9; wreg = 1'b1; wdata = d;
      while (1) begin
         #1;
         if (!stall_req_o) break;
         if (cyc > 30) begin chk({tag, "_timeout"}, {31'd0, stall_req_o}, 32'd0); break; end
         chk({tag, "_wreg_stall"}, {31'd0, wreg_o}, 32'd0);
         chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd1);
         if (mem_we_o) begin
            chk({tag, "_addr"}, mem_a_o, base + nw);
            chk({tag, "_byte"}, {24'd0, mem_dout_o}, {24'd0, d[8*nw +: 8]});
            nw++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      chk({tag, "_stall_len"}, cyc, n);
      chk({tag, "_nwrites"}, nw, n);
      chk({tag, "_wreg_done"}, {31'd0, wreg_o}, 32'd0);
      chk({tag, "_we_done"}, {31'd0, mem_we_o}, 32'd0);
      @(posedge clk); #1;
      nop();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
      mem_addr = 32'd0;
      // ADD inputs during reset must not leak to outputs
      opcode = OPC_ADD; funct3 = 3'd0; wd = 5'd3; wreg = 1'b1; wdata = 32'h5;
      @(posedge clk); @(posedge clk); #2;
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
      chk("rst_wd", {27'd0, wd_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
      chk("rst_we", {31'd0, mem_we_o}, 32'd0);
      chk("rst_addr", mem_a_o, 32'd0);

      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("add_wdata", wdata_o, 32'h5);
      chk("add_wd", {27'd0, wd_o}, 32'd3);
      chk("add_wreg", {31'd0, wreg_o}, 32'd1);
      chk("add_stall", {31'd0, stall_req_o}, 32'd0);
      chk("add_we", {31'd0, mem_we_o}, 32'd0);
      @(posedge clk); #1;
      nop();

      preload(10'h100, 8'h78); preload(10'h101, 8'h56);
      preload(10'h102, 8'h34); preload(10'h103, 8'h12);
      preload(10'h020, 8'h80);
      preload(10'h030, 8'h00); preload(10'h031, 8'h80);
      preload(10'h3FE, 8'h11); preload(10'h3FF, 8'h22);
      preload(10'h000, 8'h33); preload(10'h001, 8'h44);
      for (int i = 0; i < 4; i++) preload(10'h040 + 10'(i), 8'h00);
      for (int i = 0; i < 4; i++) preload(10'h080 + 10'(i), 8'h00);

      run_load("lw",     32'h100, 3'b010, 4, 32'h12345678, 5, -1);
      run_load("lb",     32'h020, 3'b000, 1, 32'hFFFFFF80, 2, -1);
      run_load("lbu",    32'h020, 3'b100, 1, 32'h00000080, 2, -1);
      run_load("lh",     32'h030, 3'b001, 2, 32'hFFFF8000, 3, -1);
      run_load("lhu",    32'h030, 3'b101, 2, 32'h00008000, 3, -1);
      run_load("lw_wrap",32'hFFFFFFFE, 3'b010, 4, 32'h44332211, 5, -1);
      run_load("lw_rdy", 32'h100, 3'b010, 4, 32'h12345678, 7, 2);

      run_store("sw", 32'h40, 3'b010, 4, 32'hDEADBEEF);
      chk("sw_ram0", {24'd0, ram[10'h040]}, 32'hEF);
      chk("sw_ram1", {24'd0, ram[10'h041]}, 32'hBE);
      chk("sw_ram2", {24'd0, ram[10'h042]}, 32'hAD);
      chk("sw_ram3", {24'd0, ram[10'h043]}, 32'hDE);

      run_store("sh", 32'h50, 3'b001, 2, 32'h1234A55A);
      chk("sh_ram0", {24'd0, ram[10'h050]}, 32'h5A);
      chk("sh_ram1", {24'd0, ram[10'h051]}, 32'hA5);

      // illegal widths act as no-ops
      opcode = OPC_LOAD; funct3 = 3'b011; mem_addr = 32'h100; wd = 5'd4; wreg = 1'b1; wdata = 32'h77;
      #1;
      chk("bad_ld_stall", {31'd0, stall_req_o}, 32'd0);
      chk("bad_ld_wreg", {31'd0, wreg_o}, 32'd0);
      opcode = OPC_STORE; funct3 = 3'b100;
      #1;
      chk("bad_st_stall", {31'd0, stall_req_o}, 32'd0);
      chk("bad_st_we", {31'd0, mem_we_o}, 32'd0);
      @(posedge clk); #1;
      chk("bad_st_idle", {31'd0, stall_req_o}, 32'd0);

      // reset in the middle of a word store
      opcode = OPC_STORE; funct3 = 3'b010; mem_addr = 32'h80; wd = 5'd1; wreg = 1'b1; wdata = 32'hCAFEBABE;
      #1;
      chk("rsw_b0_we", {31'd0, mem_we_o}, 32'd1);
      @(posedge clk); #2;
      chk("rsw_b1_addr", mem_a_o, 32'h81);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rsw_rst_we", {31'd0, mem_we_o}, 32'd0);
      chk("rsw_rst_stall", {31'd0, stall_req_o}, 32'd0);
      chk("rsw_rst_wreg", {31'd0, wreg_o}, 32'd0);
      chk("rsw_rst_addr", mem_a_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      opcode = OPC_ADD; funct3 = 3'd0; wd = 5'd3; wreg = 1'b1; wdata = 32'h9;
      #1;
      chk("rsw_idle_stall", {31'd0, stall_req_o}, 32'd0);
      chk("rsw_idle_wdata", wdata_o, 32'h9);
      chk("rsw_ram0", {24'd0, ram[10'h080]}, 32'hBE);
      chk("rsw_ram1", {24'd0, ram[10'h081]}, 32'hBA);
      chk("rsw_ram2", {24'd0, ram[10'h082]}, 32'h00);
      chk("rsw_ram3", {24'd0, ram[10'h083]}, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
